// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants and types for the PMOD button conditioner
package btn_pkg;

    // Default channel count on the pmodbutled board.
    localparam int BTN_NBTN = 4;

    // 1 ms of stable level at a 12 MHz system clock.
    localparam int BTN_DEB_CYCLES_12M = 12000;

    // Length of the per-channel metastability chain.
    localparam int BTN_SYNC_STAGES = 2;

    // One bit per button channel.
    typedef logic [BTN_NBTN-1:0] btn_vec_t;

endpackage : btn_pkg

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchroniser, debounce counter, sticky edge flags
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   btn_raw_i    unsynchronised button level, 1 = pressed
//   evt_clr_i    write-1-to-clear strobe for both event flags
//   btn_state_o  debounced level
//   rise_evt_o   sticky: a press was accepted
//   fall_evt_o   sticky: a release was accepted
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = BTN_DEB_CYCLES_12M
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    input  logic evt_clr_i,
    output logic btn_state_o,
    output logic rise_evt_o,
    output logic fall_evt_o
);

    localparam int              CNT_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [BTN_SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       state_q, state_d;
    logic                       rise_q, rise_d;
    logic                       fall_q, fall_d;
    logic                       s;
    logic                       accept;

    assign s = sync_q[BTN_SYNC_STAGES-1];

    always_comb begin
        accept  = 1'b0;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (s == state_q) begin
            // Level agrees with the published state: any partial count is a glitch.
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            accept  = 1'b1;
            state_d = s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // A new edge takes priority over a clear arriving in the same cycle.
        rise_d = (accept & s)  | (rise_q & ~evt_clr_i);
        fall_d = (accept & ~s) | (fall_q & ~evt_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[BTN_SYNC_STAGES-2:0], btn_raw_i};
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign btn_state_o = state_q;
    assign rise_evt_o  = rise_q;
    assign fall_evt_o  = fall_q;

endmodule : btn_debounce_ch

// File: rtl/pmod_btn_conditioner.sv
// rtl/pmod_btn_conditioner.sv - debounced PMOD buttons with sticky rise/fall events for the SoC IPORT
//
// Optional feature macro: BTN_IRQ_EN (adds irq_mask input and registered irq output).
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   btn_raw    unsynchronised button levels, 1 = pressed
//   evt_clr    write-1-to-clear strobes, one per channel
//   irq_mask   per-channel interrupt enable (BTN_IRQ_EN only)
//   btn_state  debounced levels
//   rise_evt   sticky press flags
//   fall_evt   sticky release flags
//   irq        level interrupt (BTN_IRQ_EN only)
module pmod_btn_conditioner
    import btn_pkg::*;
#(
    parameter int NBTN       = BTN_NBTN,
    parameter int DEB_CYCLES = BTN_DEB_CYCLES_12M
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn_raw,
    input  logic [NBTN-1:0] evt_clr,
`ifdef BTN_IRQ_EN
    input  logic [NBTN-1:0] irq_mask,
    output logic            irq,
`endif
    output logic [NBTN-1:0] btn_state,
    output logic [NBTN-1:0] rise_evt,
    output logic [NBTN-1:0] fall_evt
);

    for (genvar i = 0; i < NBTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_ch (
            .clk_i       (clk),
            .rst_ni      (reset),
            .btn_raw_i   (btn_raw[i]),
            .evt_clr_i   (evt_clr[i]),
            .btn_state_o (btn_state[i]),
            .rise_evt_o  (rise_evt[i]),
            .fall_evt_o  (fall_evt[i])
        );
    end

`ifdef BTN_IRQ_EN
    logic irq_q, irq_d;

    // Built from the registered flags, so irq lags a clear or mask change by one cycle.
    always_comb begin
        irq_d = |(irq_mask & (rise_evt | fall_evt));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule : pmod_btn_conditioner

// File: tb/tb_pmod_btn_conditioner.sv
// tb/tb_pmod_btn_conditioner.sv - self-checking bench for pmod_btn_conditioner
module tb_pmod_btn_conditioner;
    import btn_pkg::*;

    localparam int NBTN = 4;
    localparam int DEB  = 8;
    localparam int LAT  = 2 + DEB;

    logic     clk;
    logic     reset;
    btn_vec_t btn_raw;
    btn_vec_t evt_clr;
    btn_vec_t irq_mask;
    btn_vec_t btn_state;
    btn_vec_t rise_evt;
    btn_vec_t fall_evt;
    logic     irq;

    int checks   = 0;
    int failures = 0;

    pmod_btn_conditioner #(
        .NBTN       (NBTN),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .evt_clr   (evt_clr),
`ifdef BTN_IRQ_EN
        .irq_mask  (irq_mask),
        .irq       (irq),
`endif
        .btn_state (btn_state),
        .rise_evt  (rise_evt),
        .fall_evt  (fall_evt)
    );

`ifndef BTN_IRQ_EN
    assign irq = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] clr;
        int         ncyc;
        logic [3:0] exp_state;
        logic [3:0] exp_rise;
        logic [3:0] exp_fall;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        btn_raw = '0;
        evt_clr = '0;
        tick(3);
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        btn_raw  = '0;
        evt_clr  = '0;
        irq_mask = '0;

        // 1. Reset state
        tick(3);
        chk("reset_state", 32'(btn_state), 32'h0);
        chk("reset_rise",  32'(rise_evt),  32'h0);
        chk("reset_fall",  32'(fall_evt),  32'h0);
        chk("reset_irq",   32'(irq),       32'h0);
        reset = 1'b1;
        tick(2);

        // 2. Exact acceptance latency on channel 0
        btn_raw[0] = 1'b1;
        tick(LAT - 1);
        chk("lat_state_at9", 32'(btn_state[0]), 32'h0);
        chk("lat_rise_at9",  32'(rise_evt[0]),  32'h0);
        tick(1);
        chk("lat_state_at10", 32'(btn_state[0]), 32'h1);
        chk("lat_rise_at10",  32'(rise_evt[0]),  32'h1);

        // 3. Short pulses on channel 1 never accepted
        begin
            int bad = 0;
            for (int p = 0; p < 5; p++) begin
                btn_raw[1] = 1'b1;
                for (int c = 0; c < DEB - 1; c++) begin
                    tick(1);
                    if (btn_state[1] !== 1'b0 || rise_evt[1] !== 1'b0) bad++;
                end
                btn_raw[1] = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    tick(1);
                    if (btn_state[1] !== 1'b0 || rise_evt[1] !== 1'b0) bad++;
                end
            end
            tick(LAT);
            if (btn_state[1] !== 1'b0 || rise_evt[1] !== 1'b0) bad++;
            chk("glitch_cycles_bad", 32'(bad), 32'h0);
        end

        // 4. Clear of rise in the same cycle as a fall acceptance on channel 0
        btn_raw[0] = 1'b0;
        tick(LAT - 1);
        evt_clr[0] = 1'b1;
        tick(1);
        evt_clr[0] = 1'b0;
        chk("clr_fall_rise",  32'(rise_evt[0]),  32'h0);
        chk("clr_fall_fall",  32'(fall_evt[0]),  32'h1);
        chk("clr_fall_state", 32'(btn_state[0]), 32'h0);

        // 5. Set wins over a simultaneous clear on channel 2
        btn_raw[2] = 1'b1;
        tick(LAT - 1);
        evt_clr[2] = 1'b1;
        tick(1);
        evt_clr[2] = 1'b0;
        chk("setwins_rise2",  32'(rise_evt[2]),  32'h1);
        chk("setwins_state2", 32'(btn_state[2]), 32'h1);
        evt_clr[2] = 1'b1;
        tick(1);
        evt_clr[2] = 1'b0;
        chk("later_clr_rise2", 32'(rise_evt[2]), 32'h0);

        // Table: all channels simultaneously, double events, redundant clears
        do_reset();
        tick(1);
        vecs[0] = '{4'b1111, 4'b0000, LAT,     4'b1111, 4'b1111, 4'b0000};
        vecs[1] = '{4'b1111, 4'b1111, 1,       4'b1111, 4'b0000, 4'b0000};
        vecs[2] = '{4'b0000, 4'b0000, LAT - 1, 4'b1111, 4'b0000, 4'b0000};
        vecs[3] = '{4'b0000, 4'b0000, 1,       4'b0000, 4'b0000, 4'b1111};
        vecs[4] = '{4'b0101, 4'b0000, LAT,     4'b0101, 4'b0101, 4'b1111};
        vecs[5] = '{4'b0101, 4'b1010, 1,       4'b0101, 4'b0101, 4'b0101};
        vecs[6] = '{4'b0000, 4'b0000, LAT,     4'b0000, 4'b0101, 4'b0101};
        vecs[7] = '{4'b0000, 4'b0101, 1,       4'b0000, 4'b0000, 4'b0000};
        vecs[8] = '{4'b0000, 4'b1111, 1,       4'b0000, 4'b0000, 4'b0000};
        for (int v = 0; v < 9; v++) begin
            btn_raw = vecs[v].raw;
            evt_clr = vecs[v].clr;
            tick(vecs[v].ncyc);
            evt_clr = '0;
            chk($sformatf("vec%0d_state", v), 32'(btn_state), 32'(vecs[v].exp_state));
            chk($sformatf("vec%0d_rise", v),  32'(rise_evt),  32'(vecs[v].exp_rise));
            chk($sformatf("vec%0d_fall", v),  32'(fall_evt),  32'(vecs[v].exp_fall));
        end

`ifdef BTN_IRQ_EN
        // 6. Interrupt masking: only channel 2 contributes
        do_reset();
        tick(1);
        irq_mask   = 4'b0100;
        btn_raw[0] = 1'b1;
        tick(LAT + 2);
        chk("irq_ch0_masked", 32'(irq), 32'h0);
        chk("irq_ch0_rise",   32'(rise_evt[0]), 32'h1);
        btn_raw[2] = 1'b1;
        tick(LAT);
        chk("irq_ch2_set_cycle", 32'(irq), 32'h0);
        tick(1);
        chk("irq_ch2_asserted", 32'(irq), 32'h1);
        evt_clr[2] = 1'b1;
        tick(1);
        evt_clr[2] = 1'b0;
        chk("irq_after_clr_edge", 32'(irq), 32'h1);
        tick(1);
        chk("irq_dropped", 32'(irq), 32'h0);
        irq_mask = '0;
`endif

        // 7. Reset mid-debounce of channel 3
        do_reset();
        tick(1);
        btn_raw = 4'b1000;
        tick(LAT);
        chk("pre_rst_state3", 32'(btn_state), 32'h8);
        btn_raw = 4'b0000;
        tick(5);
        reset = 1'b0;
        #1;
        chk("midrst_state", 32'(btn_state), 32'h0);
        chk("midrst_rise",  32'(rise_evt),  32'h0);
        chk("midrst_fall",  32'(fall_evt),  32'h0);
        chk("midrst_irq",   32'(irq),       32'h0);
        btn_raw = 4'b1000;
        tick(3);
        reset = 1'b1;
        tick(LAT - 1);
        chk("postrst_state_at9",  32'(btn_state), 32'h0);
        tick(1);
        chk("postrst_state_at10", 32'(btn_state), 32'h8);
        chk("postrst_rise_at10",  32'(rise_evt),  32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pmod_btn_conditioner
